// File: rtl/ram_arb_pkg.sv
// Shared types for ram_arbiter: state encoding, default sizes, read-tag record.
package ram_arb_pkg;

    localparam int RAM_ARB_DW = 8;
    localparam int RAM_ARB_AW = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic vld;
        logic id;
    } rd_tag_t;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// 2-way round-robin picker; grant is combinational, zero latency.
// Losing requester simply stays pending; rr_ptr moves to the other master after any grant.
module rr_arb2 (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic rr_ptr_q;
    logic rr_ptr_d;

    always_comb begin
        gnt0     = en & req0 & (~req1 | ~rr_ptr_q);
        gnt1     = en & req1 & (~req0 |  rr_ptr_q);
        rr_ptr_d = rr_ptr_q;
        if (gnt0) begin
            rr_ptr_d = 1'b1;
        end else if (gnt1) begin
            rr_ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master round-robin sequencer for a single-port sync-read RAM; optional clearing sweep under RAM_ARB_INIT_EN.
// Latency: command on RAM pins 1 cycle after accept, tagged rvalid/rdata 2 cycles after accept.
// Backpressure: gnt is the only accept; a request not granted must be held until it is.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DW = RAM_ARB_DW,
    parameter int AW = RAM_ARB_AW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          wr0,
    input  logic          wr1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          init_done,
    output logic          ram_we,
    output logic          ram_re,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    logic          en;
    logic          ram_we_q,   ram_we_d;
    logic          ram_re_q,   ram_re_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_din_q,  ram_din_d;
    rd_tag_t       tag0_q,     tag0_d;
    rd_tag_t       tag1_q,     tag1_d;

`ifdef RAM_ARB_INIT_EN
    arb_state_e    state_q,     state_d;
    logic [AW:0]   init_cnt_q,  init_cnt_d;
    logic          init_done_q, init_done_d;

    // Sweep issues one zero-write per cycle, then spends one more cycle before opening RUN.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        if (state_q == INIT) begin
            if (!init_cnt_q[AW]) begin
                init_cnt_d = init_cnt_q + 1'b1;
            end else begin
                state_d     = RUN;
                init_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
        end
    end

    assign en        = init_done_q;
    assign init_done = init_done_q;
`else
    assign en        = 1'b1;
    assign init_done = 1'b1;
`endif

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .req0    (req0),
        .req1    (req1),
        .gnt0    (gnt0),
        .gnt1    (gnt1)
    );

    always_comb begin
        ram_we_d   = 1'b0;
        ram_re_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        tag0_d     = '0;
        tag1_d     = tag0_q;
        if (gnt0) begin
            ram_we_d   = wr0;
            ram_re_d   = ~wr0;
            ram_addr_d = addr0;
            ram_din_d  = wr0 ? wdata0 : ram_din_q;
            tag0_d.vld = ~wr0;
            tag0_d.id  = 1'b0;
        end else if (gnt1) begin
            ram_we_d   = wr1;
            ram_re_d   = ~wr1;
            ram_addr_d = addr1;
            ram_din_d  = wr1 ? wdata1 : ram_din_q;
            tag0_d.vld = ~wr1;
            tag0_d.id  = 1'b1;
        end
`ifdef RAM_ARB_INIT_EN
        if (state_q == INIT && !init_cnt_q[AW]) begin
            ram_we_d   = 1'b1;
            ram_addr_d = init_cnt_q[AW-1:0];
            ram_din_d  = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_we_q   <= 1'b0;
            ram_re_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            tag0_q     <= '0;
            tag1_q     <= '0;
        end else begin
            ram_we_q   <= ram_we_d;
            ram_re_q   <= ram_re_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            tag0_q     <= tag0_d;
            tag1_q     <= tag1_d;
        end
    end

    assign ram_we   = ram_we_q;
    assign ram_re   = ram_re_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign rvalid0  = tag1_q.vld & ~tag1_q.id;
    assign rvalid1  = tag1_q.vld &  tag1_q.id;
    assign rdata    = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 16x8 sync-read RAM attached.
module tb_ram_arbiter;

    localparam int DW = 8;
    localparam int AW = 4;
`ifdef RAM_ARB_INIT_EN
    localparam logic INIT_EXP = 1'b0;
`else
    localparam logic INIT_EXP = 1'b1;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req0, req1, wr0, wr1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, init_done;
    logic [DW-1:0] rdata;
    logic          ram_we, ram_re;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    logic [DW-1:0] mem [16];
    logic [DW-1:0] wv  [4];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        if (ram_re) ram_dout <= mem[ram_addr];
    end

    ram_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0      (req0),
        .req1      (req1),
        .wr0       (wr0),
        .wr1       (wr1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .init_done (init_done),
        .ram_we    (ram_we),
        .ram_re    (ram_re),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle;
        req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_gnt0"},      gnt0,      0);
        chk({pfx, "_gnt1"},      gnt1,      0);
        chk({pfx, "_rvalid0"},   rvalid0,   0);
        chk({pfx, "_rvalid1"},   rvalid1,   0);
        chk({pfx, "_ram_we"},    ram_we,    0);
        chk({pfx, "_ram_re"},    ram_re,    0);
        chk({pfx, "_ram_addr"},  ram_addr,  0);
        chk({pfx, "_ram_din"},   ram_din,   0);
        chk({pfx, "_init_done"}, init_done, INIT_EXP);
    endtask

`ifdef RAM_ARB_INIT_EN
    // Entered mid-cycle just after reset release; leaves in the first RUN cycle.
    task automatic wait_init;
        int k;
        k = 0;
        while (init_done !== 1'b1 && k < 40) begin
            chk("init_gnt0", gnt0, 0);
            tick;
            k++;
            if (k <= 16) begin
                chk("init_we",   ram_we,   1);
                chk("init_addr", ram_addr, k - 1);
                chk("init_din",  ram_din,  0);
            end
        end
        chk("init_len", k, 17);
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        wv[0] = 8'd43; wv[1] = 8'd53; wv[2] = 8'd3; wv[3] = 8'd4;
        set_idle;
        reset_n = 1'b0;
        #12;
        chk_reset("rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

`ifdef RAM_ARB_INIT_EN
        req0 = 1'b1; wr0 = 1'b0; addr0 = 4'd7;
        wait_init;
        #1;
        chk("init_first_gnt0", gnt0, 1);
        tick;
        set_idle;
        chk("init_first_re", ram_re, 1);
        tick;
        chk("init_first_rv", rvalid0, 1);
        chk("init_first_rd", rdata, 0);
        for (int c = 0; c < 18; c++) begin
            if (c < 16) begin
                req0 = 1'b1; wr0 = 1'b0; addr0 = 4'(c);
            end else begin
                req0 = 1'b0;
            end
            #1;
            if (c < 16) chk("init_rd_gnt0", gnt0, 1);
            if (c >= 2) begin
                chk("init_rd_rv", rvalid0, 1);
                chk("init_rd_data", rdata, 0);
            end
            tick;
        end
        set_idle;
`endif

        // m0 alone: four writes then four reads back-to-back
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                req0 = 1'b1; wr0 = (c < 4); addr0 = 4'(c % 4); wdata0 = wv[c % 4];
            end else begin
                set_idle;
            end
            #1;
            if (c < 8) begin
                chk("t1_gnt0", gnt0, 1);
                chk("t1_gnt1", gnt1, 0);
            end
            if (c >= 1 && c <= 8) begin
                chk("t1_we",   ram_we,   ((c - 1) < 4));
                chk("t1_re",   ram_re,   ((c - 1) >= 4));
                chk("t1_addr", ram_addr, (c - 1) % 4);
                if ((c - 1) < 4) chk("t1_din", ram_din, wv[c - 1]);
            end
            chk("t1_rv0", rvalid0, (c >= 6));
            if (c >= 6) chk("t1_rdata", rdata, wv[c - 6]);
            tick;
        end

        // m1 alone reads addr 2; leaves rr_ptr pointing at m0
        req1 = 1'b1; wr1 = 1'b0; addr1 = 4'd2;
        #1;
        chk("m1_gnt1", gnt1, 1);
        chk("m1_gnt0", gnt0, 0);
        tick;
        set_idle;
        chk("m1_re",   ram_re,   1);
        chk("m1_addr", ram_addr, 2);
        tick;
        chk("m1_rv1",   rvalid1, 1);
        chk("m1_rv0",   rvalid0, 0);
        chk("m1_rdata", rdata,   3);

        for (int c = 0; c < 3; c++) begin
            tick;
            chk("idle_we",   ram_we,   0);
            chk("idle_re",   ram_re,   0);
            chk("idle_addr", ram_addr, 2);
            chk("idle_rv1",  rvalid1,  0);
        end

        // both masters every cycle: grants alternate starting with m0
        for (int c = 0; c < 8; c++) begin
            if (c < 6) begin
                req0 = 1'b1; wr0 = 1'b0; addr0 = 4'd0;
                req1 = 1'b1; wr1 = 1'b0; addr1 = 4'd1;
            end else begin
                set_idle;
            end
            #1;
            if (c < 6) begin
                chk("t2_gnt0", gnt0, (c % 2 == 0));
                chk("t2_gnt1", gnt1, (c % 2 == 1));
            end
            if (c >= 1 && c <= 6) begin
                chk("t2_re",   ram_re,   1);
                chk("t2_addr", ram_addr, (c - 1) % 2);
            end
            if (c >= 2) begin
                chk("t2_rv0",   rvalid0, ((c - 2) % 2 == 0));
                chk("t2_rv1",   rvalid1, ((c - 2) % 2 == 1));
                chk("t2_rdata", rdata,   ((c - 2) % 2 == 0) ? 43 : 53);
            end
            tick;
        end

        // write-then-read of the same address by different masters
        req0 = 1'b1; wr0 = 1'b1; addr0 = 4'd5; wdata0 = 8'd69;
        #1;
        chk("t3_gnt0", gnt0, 1);
        tick;
        req0 = 1'b0;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 4'd5;
        #1;
        chk("t3_gnt1", gnt1,     1);
        chk("t3_we",   ram_we,   1);
        chk("t3_addr", ram_addr, 5);
        chk("t3_din",  ram_din,  69);
        tick;
        set_idle;
        chk("t3_re", ram_re, 1);
        tick;
        chk("t3_rv1",   rvalid1, 1);
        chk("t3_rdata", rdata,   69);

        // reset one cycle after a read accept; m0 grant moves rr_ptr to m1 first
        req0 = 1'b1; wr0 = 1'b0; addr0 = 4'd0;
        #1;
        chk("t4_gnt0", gnt0, 1);
        tick;
        set_idle;
        reset_n = 1'b0;
        #1;
        chk_reset("t4_mid");
        tick;
        chk("t4_rv0_rst", rvalid0, 0);
        tick;
        reset_n = 1'b1;
`ifdef RAM_ARB_INIT_EN
        wait_init;
`else
        tick;
`endif
        chk("t4_rv0_post", rvalid0, 0);
        req0 = 1'b1; wr0 = 1'b0; addr0 = 4'd1;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 4'd2;
        #1;
        chk("t4_first_gnt0", gnt0, 1);
        chk("t4_first_gnt1", gnt1, 0);
        tick;
        set_idle;
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester round-robin arbiter and sequencer for the single-port 16x8 `ram` block (registered we/re/addr/din, synchronous read with `dout` valid the cycle after `re`). It accepts read/write requests from two independent masters, issues at most one RAM command per clock, and routes read data back with a tagged valid pulse. It sits between the RAM and its clients so the RAM itself stays a plain storage array.

## Interface
- `DW`, 8, data width; matches RAM `din`/`dout`.
- `AW`, 4, address width; RAM depth is 2**AW.

- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  request from master 0/1; held with its fields until granted.
- `wr0`, `wr1`  in  1  1 = write, 0 = read.
- `addr0`, `addr1`  in  AW  request address.
- `wdata0`, `wdata1`  in  DW  write data.
- `gnt0`, `gnt1`  out  1  combinational accept; `req & gnt` = request taken this cycle.
- `rvalid0`, `rvalid1`  out  1  one-cycle pulse, read data on `rdata` belongs to that master.
- `rdata`  out  DW  shared read-data bus, equals `ram_dout`.
- `init_done`  out  1  arbiter accepting requests.
- `ram_we`, `ram_re`  out  1  RAM command strobes (registered).
- `ram_addr`  out  AW  RAM address (registered).
- `ram_din`  out  DW  RAM write data (registered).
- `ram_dout`  in  DW  RAM read data.

## Operation
- States: `INIT` (clearing sweep, only with `RAM_ARB_INIT_EN`), `RUN`. Reset enters `INIT` if compiled in, else `RUN`.
- `RUN`: each cycle at most one grant. Only one requester -> it wins. Both -> winner is the one selected by the round-robin pointer `rr_ptr`; after any grant, `rr_ptr` points to the other master. `rr_ptr` reset value 0 (master 0 first).
- No grant in `INIT`; `gnt0`/`gnt1` forced 0 while `init_done`=0.
- Granted request registered into `ram_we`/`ram_re`/`ram_addr`/`ram_din`; `ram_we` and `ram_re` never both 1. No grant -> both strobes 0 next cycle, addr/din hold.
- Reads tagged with master id in a 2-stage shift pipeline; tag exit drives `rvalid0`/`rvalid1`.
- Back-to-back accepts allowed every cycle (throughput 1 command/clk); reads and writes freely interleave; RAM order equals grant order, so a read granted after a write to the same address returns the new data.
- Reset (any time, including mid-read): all in-flight tags dropped, no `rvalid` issued for them; `rr_ptr` restored to 0.

## Timing
- Reset values: `gnt*`=0, `rvalid*`=0, `ram_we`=0, `ram_re`=0, `ram_addr`=0, `ram_din`=0, `init_done`=0 with init, 1 without.
- Cycle N: accept (`gnt` high). Cycle N+1: command on RAM pins. Cycle N+2: `rvalid` high, `rdata` valid (read latency 2 from accept).
- Write completes at the edge ending N+1; no write acknowledge beyond `gnt`.
- `gnt` depends combinationally on `req*` and state; requesters must not make `req` depend combinationally on `gnt`.

## Configuration
- `RAM_ARB_INIT_EN` defined: after reset, `INIT` issues 2**AW writes of 0 to addresses 0..2**AW-1, one per cycle starting the first cycle after reset release; then `RUN`, `init_done` rises the cycle after the last write is on the pins (cycle 17 for AW=4). Requests held during `INIT` are granted in the first `RUN` cycle.
- Not defined: no `INIT` state, `init_done` tied 1, RAM contents undefined until written.

## Structure
- Package `ram_arb_pkg`: state enum (`INIT`, `RUN`), default `DW`/`AW` constants, read-tag struct (valid, master id).
- One sub-module: `rr_arb2`, 2-way round-robin picker (inputs req0/req1, enable; outputs gnt0/gnt1; holds `rr_ptr`).

## Test plan
- Single master writes 43,53,3,4 to addr 0..3, then reads 0..3 -> `rvalid0` pulses 2 cycles after each accept with `rdata` 43,53,3,4.
- Both masters request every cycle (m0 read addr 0, m1 read addr 1) -> grants alternate 0,1,0,1 starting with m0; rvalids alternate, data correct per master.
- m0 writes 69 to addr 5 in cycle N, m1 reads addr 5 in cycle N+1 -> m1 gets 69.
- Reset asserted one cycle after a read accept -> no `rvalid`, all outputs at reset values, first grant after release goes to m0.
- With `RAM_ARB_INIT_EN`: reads of all 16 addresses after `init_done` return 0; `req0` held during init granted on the first `RUN` cycle, not earlier.
- Idle cycles (no req) -> `ram_we`=`ram_re`=0, `rr_ptr` unchanged.
